// File: rtl/prime_trial_ctrl_if.sv
// Handshake bundle between the trial-division sequencer and its neighbours:
// the candidate source, the iterative divider, and the verdict consumer.
// The slave modport is the sequencer's view; master is the environment's view.
//
// Every channel is val/rdy: a transfer happens on a rising clock edge where
// val and rdy are both high; once val is raised it stays high, with its data
// unchanged, until that transfer.
interface prime_trial_ctrl_if #(parameter int NBITS = 16);
  logic [NBITS-1:0] cand;
  logic             cand_val;
  logic             cand_rdy;
  logic [NBITS-1:0] div_opa;
  logic [NBITS-1:0] div_opb;
  logic             div_istream_val;
  logic             div_istream_rdy;
  logic [NBITS-1:0] div_result;
  logic             div_ostream_val;
  logic             div_ostream_rdy;
  logic             is_prime;
  logic             prime_val;
  logic             prime_rdy;

  modport slave (
    input  cand, cand_val, div_istream_rdy, div_result, div_ostream_val, prime_rdy,
    output cand_rdy, div_opa, div_opb, div_istream_val, div_ostream_rdy,
           is_prime, prime_val
  );

  modport master (
    output cand, cand_val, div_istream_rdy, div_result, div_ostream_val, prime_rdy,
    input  cand_rdy, div_opa, div_opb, div_istream_val, div_ostream_rdy,
           is_prime, prime_val
  );
endinterface

// File: rtl/prime_trial_ctrl.sv
// Trial-division sequencer feeding an iterative divider.
// Takes a candidate N, asks the divider for floor(N/d) for d = 2, 3, ...,
// and emits one prime/composite verdict per candidate. The search stops when
// the quotient drops below the divisor, so no square root is needed.
//
// Build option: PRIME_TRIAL_CTRL_ODD_SKIP_EN
//   defined   -> divisors 2, 3, 5, 7, 9, ... (odd only after 2)
//   undefined -> divisors 2, 3, 4, 5, ...
// Verdicts match in both builds; only the number of divider requests changes.
module prime_trial_ctrl #(
  parameter int NBITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  prime_trial_ctrl_if.slave   bus,
  output logic [1:0]          state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [NBITS-1:0] n_q;
  logic [NBITS-1:0] d_q;
  logic [NBITS-1:0] opa_q;
  logic [NBITS-1:0] opb_q;
  logic             cand_rdy_q;
  logic             istream_val_q;
  logic             ostream_rdy_q;
  logic             prime_val_q;
  logic             is_prime_q;

  logic [NBITS-1:0]   d_d;
  logic [2*NBITS-1:0] prod_d;
  logic [2*NBITS-1:0] n_ext_d;

  // Next divisor to try; the step width stays NBITS since d never passes 257.
`ifdef PRIME_TRIAL_CTRL_ODD_SKIP_EN
  assign d_d = (d_q == NBITS'(2)) ? NBITS'(3) : d_q + NBITS'(2);
`else
  assign d_d = d_q + NBITS'(1);
`endif

  // Full-width product so q*d == N never aliases through truncation.
  assign prod_d  = {{NBITS{1'b0}}, bus.div_result} * {{NBITS{1'b0}}, d_q};
  assign n_ext_d = {{NBITS{1'b0}}, n_q};

  // Sequencer FSM: every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      n_q           <= '0;
      d_q           <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      cand_rdy_q    <= 1'b1;
      istream_val_q <= 1'b0;
      ostream_rdy_q <= 1'b0;
      prime_val_q   <= 1'b0;
      is_prime_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cand_val && cand_rdy_q) begin
            n_q        <= bus.cand;
            d_q        <= NBITS'(2);
            cand_rdy_q <= 1'b0;
            if (bus.cand < NBITS'(2)) begin
              // 0 and 1 are not prime; answer without touching the divider.
              is_prime_q  <= 1'b0;
              prime_val_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              opa_q         <= bus.cand;
              opb_q         <= NBITS'(2);
              istream_val_q <= 1'b1;
              state_q       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (istream_val_q && bus.div_istream_rdy) begin
            istream_val_q <= 1'b0;
            ostream_rdy_q <= 1'b1;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (ostream_rdy_q && bus.div_ostream_val) begin
            ostream_rdy_q <= 1'b0;
            if (bus.div_result < d_q) begin
              // Every divisor up to sqrt(N) has been ruled out.
              is_prime_q  <= 1'b1;
              prime_val_q <= 1'b1;
              state_q     <= DONE;
            end else if (prod_d == n_ext_d) begin
              is_prime_q  <= 1'b0;
              prime_val_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              d_q           <= d_d;
              opb_q         <= d_d;
              istream_val_q <= 1'b1;
              state_q       <= ISSUE;
            end
          end
        end
        DONE: begin
          if (prime_val_q && bus.prime_rdy) begin
            prime_val_q <= 1'b0;
            cand_rdy_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cand_rdy        = cand_rdy_q;
  assign bus.div_opa         = opa_q;
  assign bus.div_opb         = opb_q;
  assign bus.div_istream_val = istream_val_q;
  assign bus.div_ostream_rdy = ostream_rdy_q;
  assign bus.is_prime        = is_prime_q;
  assign bus.prime_val       = prime_val_q;
  assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_prime_trial_ctrl.sv
// Directed bench for prime_trial_ctrl with a behavioural divider model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_prime_trial_ctrl;
  localparam int NBITS   = 16;
  localparam int DIV_LAT = 1;
  localparam int BUDGET  = 5000;

`ifdef PRIME_TRIAL_CTRL_ODD_SKIP_EN
  localparam int R97 = 6;   localparam int LAST97 = 11;
  localparam int R91 = 4;   localparam int R65521 = 129;
`else
  localparam int R97 = 9;   localparam int LAST97 = 10;
  localparam int R91 = 6;   localparam int R65521 = 255;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] state_dbg;

  prime_trial_ctrl_if #(.NBITS(NBITS)) bus();

  prime_trial_ctrl #(.NBITS(NBITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Divider model state and request log
  logic             req_seen = 1'b0, resp_seen = 1'b0;
  logic             stall_en = 1'b0;
  logic [NBITS-1:0] cap_opa = '0, cap_opb = '0, pend_q = '0;
  logic             busy = 1'b0;
  int               cnt = 0;
  int               val_cycles = 0;
  int               unstable_cnt = 0;
  logic             hold_pend = 1'b0;
  logic [NBITS-1:0] hold_opa = '0, hold_opb = '0;
  logic [NBITS-1:0] log_opa[$];
  logic [NBITS-1:0] log_opb[$];

  // Scoreboard
  logic [0:0] exp_q[$];

  // Results of the latest run_cand call
  int               last_reqs, last_lat, last_val_cycles;
  logic [NBITS-1:0] last_first_opa, last_first_opb, last_final_opb;

  // Request monitor: records transfers and checks request stability.
  always @(posedge clk) begin
    req_seen  = bus.div_istream_val && bus.div_istream_rdy;
    resp_seen = bus.div_ostream_val && bus.div_ostream_rdy;
    if (bus.div_istream_val) val_cycles++;
    if (hold_pend && (!bus.div_istream_val || bus.div_opa != hold_opa ||
                      bus.div_opb != hold_opb))
      unstable_cnt++;
    hold_pend = bus.div_istream_val && !bus.div_istream_rdy && !reset;
    hold_opa  = bus.div_opa;
    hold_opb  = bus.div_opb;
    if (req_seen) begin
      cap_opa = bus.div_opa;
      cap_opb = bus.div_opb;
      log_opa.push_back(bus.div_opa);
      log_opb.push_back(bus.div_opb);
    end
  end

  // Divider model: fixed latency, one request in flight, optional rdy stalls.
  always @(negedge clk) begin
    if (reset) begin
      busy                = 1'b0;
      cnt                 = 0;
      bus.div_ostream_val = 1'b0;
      bus.div_result      = '0;
      bus.div_istream_rdy = 1'b0;
    end else begin
      if (resp_seen) bus.div_ostream_val = 1'b0;
      if (req_seen) begin
        busy   = 1'b1;
        cnt    = DIV_LAT;
        pend_q = cap_opa / cap_opb;
      end
      if (busy) begin
        if (cnt == 0) begin
          bus.div_ostream_val = 1'b1;
          bus.div_result      = pend_q;
          busy                = 1'b0;
        end else begin
          cnt--;
        end
      end
      bus.div_istream_rdy = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Driver: offer one candidate, collect its verdict, hold prime_rdy low for
  // stall_cycles once the verdict is up (caller lowers prime_rdy beforehand).
  task automatic run_cand(input logic [NBITS-1:0] n, input logic exp_prime,
                          input int exp_reqs, input int stall_cycles,
                          input string name);
    int   base, vbase, t, rdy_hi;
    logic [0:0] exp_v;
    base  = log_opb.size();
    vbase = val_cycles;
    exp_q.push_back(exp_prime);
    @(negedge clk);
    bus.cand     = n;
    bus.cand_val = 1'b1;
    t = 0;
    while (!bus.cand_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 200) begin
      n_bad++;
      $display("FAIL %s accept: cand_rdy never high in %0d cycles", name, t);
    end
    @(negedge clk);
    bus.cand_val = 1'b0;
    t = 0;
    rdy_hi = 0;
    while (!bus.prime_val && t < BUDGET) begin
      if (bus.cand_rdy) rdy_hi++;
      @(negedge clk);
      t++;
    end
    last_lat = t;
    n_cmp++;
    if (t >= BUDGET) begin
      n_bad++;
      $display("FAIL %s verdict: prime_val not seen within %0d cycles", name, t);
    end
    n_cmp++;
    if (rdy_hi !== 0) begin
      n_bad++;
      $display("FAIL %s busy_rdy: cand_rdy high %0d cycles, want 0", name, rdy_hi);
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (bus.is_prime !== exp_v) begin
      n_bad++;
      $display("FAIL %s is_prime: got %0b want %0b", name, bus.is_prime, exp_v);
    end
    last_reqs       = log_opb.size() - base;
    last_val_cycles = val_cycles - vbase;
    last_first_opa  = (last_reqs > 0) ? log_opa[base] : '0;
    last_first_opb  = (last_reqs > 0) ? log_opb[base] : '0;
    last_final_opb  = (last_reqs > 0) ? log_opb[log_opb.size() - 1] : '0;
    n_cmp++;
    if (last_reqs !== exp_reqs) begin
      n_bad++;
      $display("FAIL %s requests: got %0d want %0d", name, last_reqs, exp_reqs);
    end
    for (int i = 0; i < stall_cycles; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.prime_val !== 1'b1 || bus.is_prime !== exp_v || bus.cand_rdy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s stall%0d: val=%0b prime=%0b cand_rdy=%0b want 1,%0b,0",
                 name, i, bus.prime_val, bus.is_prime, bus.cand_rdy, exp_v);
      end
    end
    bus.prime_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.prime_val !== 1'b0 || bus.cand_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s release: prime_val=%0b cand_rdy=%0b want 0,1",
               name, bus.prime_val, bus.cand_rdy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (bus.cand_rdy !== 1'b1 || bus.div_istream_val !== 1'b0 ||
        bus.div_ostream_rdy !== 1'b0 || bus.prime_val !== 1'b0 ||
        bus.is_prime !== 1'b0 || bus.div_opa !== '0 || bus.div_opb !== '0 ||
        state_dbg !== 2'd0) begin
      n_bad++;
      $display("FAIL %s: rdy=%0b ival=%0b ordy=%0b pval=%0b prime=%0b opa=%0d opb=%0d st=%0d want 1,0,0,0,0,0,0,0",
               name, bus.cand_rdy, bus.div_istream_val, bus.div_ostream_rdy,
               bus.prime_val, bus.is_prime, bus.div_opa, bus.div_opb, state_dbg);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2 check_reset_outputs("reset_values");
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_below_two();
    logic [NBITS-1:0] nv[2];
    nv[0] = 16'd0;
    nv[1] = 16'd1;
    for (int i = 0; i < 2; i++) begin
      run_cand(nv[i], 1'b0, 0, 0, $sformatf("n%0d", nv[i]));
      n_cmp++;
      if (last_lat !== 0 || last_val_cycles !== 0) begin
        n_bad++;
        $display("FAIL n%0d latency: wait=%0d val_cycles=%0d want 0,0",
                 nv[i], last_lat, last_val_cycles);
      end
    end
  endtask

  task automatic test_first_divisor();
    run_cand(16'd2, 1'b1, 1, 0, "n2");
    n_cmp++;
    if (last_first_opa !== 16'd2 || last_first_opb !== 16'd2) begin
      n_bad++;
      $display("FAIL n2 operands: opa=%0d opb=%0d want 2,2", last_first_opa, last_first_opb);
    end
    run_cand(16'd3, 1'b1, 1, 0, "n3");
    run_cand(16'd4, 1'b0, 1, 0, "n4");
  endtask

  task automatic test_prime_97();
    run_cand(16'd97, 1'b1, R97, 0, "n97");
    n_cmp++;
    if (last_final_opb !== 16'(LAST97)) begin
      n_bad++;
      $display("FAIL n97 last_d: got %0d want %0d", last_final_opb, LAST97);
    end
  endtask

  task automatic test_composite();
    run_cand(16'd91, 1'b0, R91, 0, "n91");
    n_cmp++;
    if (last_final_opb !== 16'd7) begin
      n_bad++;
      $display("FAIL n91 last_d: got %0d want 7", last_final_opb);
    end
    run_cand(16'd65535, 1'b0, 2, 0, "n65535");
    n_cmp++;
    if (last_final_opb !== 16'd3) begin
      n_bad++;
      $display("FAIL n65535 last_d: got %0d want 3", last_final_opb);
    end
  endtask

  task automatic test_stall();
    int ubase;
    ubase         = unstable_cnt;
    stall_en      = 1'b1;
    bus.prime_rdy = 1'b0;
    run_cand(16'd65521, 1'b1, R65521, 5, "n65521");
    stall_en = 1'b0;
    n_cmp++;
    if (unstable_cnt - ubase !== 0) begin
      n_bad++;
      $display("FAIL n65521 req_stable: %0d unstable cycles want 0", unstable_cnt - ubase);
    end
  endtask

  task automatic test_reset_mid();
    int t, pv;
    @(negedge clk);
    bus.cand     = 16'd221;
    bus.cand_val = 1'b1;
    @(negedge clk);
    bus.cand_val = 1'b0;
    t = 0;
    while (!bus.div_ostream_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 100) begin
      n_bad++;
      $display("FAIL n221 wait_state: div_ostream_rdy never high in %0d cycles", t);
    end
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_abort");
    @(negedge clk);
    #1 reset = 1'b0;
    pv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.prime_val || bus.div_istream_val) pv++;
    end
    n_cmp++;
    if (pv !== 0) begin
      n_bad++;
      $display("FAIL n221 no_verdict: %0d cycles with activity want 0", pv);
    end
    run_cand(16'd13, 1'b1, 3, 0, "n13");
  endtask

  // Sequence and final report
  initial begin
    bus.cand      = '0;
    bus.cand_val  = 1'b0;
    bus.prime_rdy = 1'b1;
    test_reset();
    test_below_two();
    test_first_divisor();
    test_prime_97();
    test_composite();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
